prf_free_list: RTL and testbench
================================

// Module: prf_free_list
// PURPOSE
//  Physical-register free list feeding the dual-issue rename stage.
//  - Hands out up to 2 free PRF numbers per cycle to the rename map table (prf_rd_new of inst0/inst1).
//  - Takes back up to 2 stale PRFs per cycle from commit.
//  - Keeps a committed head pointer so a recover rolls the speculative head back in one cycle.
// PARAMETERS
//  PRF_NUM        64  physical registers in total
//  PRF_NUM_WIDTH   6  width of a PRF number
//  ARF_NUM        32  architectural registers; PRF 0..ARF_NUM-1 are mapped at reset
//  DEPTH          32  free-list entries (PRF_NUM-ARF_NUM); power of two
//  PTR_W           5  log2(DEPTH); pointers carry one extra wrap bit (PTR_W+1 bits)
// PORTS
//  clk            in   1  clock
//  rst            in   1  reset, asynchronous, active-low
//  recover        in   1  flush: restore speculative state to committed state
//  alloc_req_0    in   1  rename slot 0 needs a new PRF
//  alloc_req_1    in   1  rename slot 1 needs a new PRF
//  alloc_ok       out  1  all requested PRFs granted this cycle
//  alloc_prf_0    out  6  PRF for slot 0
//  alloc_prf_1    out  6  PRF for slot 1
//  free_0_valid   in   1  commit slot 0 releases a stale PRF
//  free_prf_0     in   6  stale PRF, slot 0
//  free_1_valid   in   1  commit slot 1 releases a stale PRF
//  free_prf_1     in   6  stale PRF, slot 1
//  commit_alloc_0 in   1  committed inst in slot 0 had allocated a PRF
//  commit_alloc_1 in   1  committed inst in slot 1 had allocated a PRF
//  free_count     out  6  current entries in list (0..DEPTH)
//  fl_err         out  1  sticky error flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=0, async):
//   - list[i]=ARF_NUM+i; spec head=0; committed head=0; tail=DEPTH (wrap bit set)
//   - free_count=32, alloc_ok=0, fl_err=0
//  Storage: ring of DEPTH entries; count = tail - spec_head (PTR_W+1-bit subtract).
//  Allocation (combinational grant, pointer update at posedge):
//   - n_req = alloc_req_0 + alloc_req_1.
//   - alloc_ok = !recover && n_req!=0 && count>=n_req. All-or-nothing: no partial grants.
//   - alloc_prf_0 = list[head].
//   - alloc_prf_1 = list[head+1] if alloc_req_0, else list[head]. Slot 0 always takes the older entry.
//   - Outputs are valid whenever the data are present, even if alloc_ok=0; the consumer uses them only when alloc_ok=1.
//   - On alloc_ok: spec_head += n_req.
//  Free (commit, non-speculative):
//   - Write free_prf_0 at tail, then free_prf_1 at next slot. A lone free_1 goes to tail.
//   - tail += free_0_valid + free_1_valid.
//   - Applied even on a recover cycle.
//   - Entries freed in cycle N become allocatable in cycle N+1 (no same-cycle bypass).
//  Committed head: chead += commit_alloc_0 + commit_alloc_1 every cycle, including recover cycles.
//  Recover: spec_head <= chead_next (chead plus this cycle's commit_alloc increments).
//   - Allocation requests in that cycle are ignored.
//   - The list is full again one cycle later, minus the live committed mappings.
//  Simultaneous alloc+free with count=0: alloc_ok=0; freed PRFs visible next cycle.
//  Wrap-around: pointers wrap modulo DEPTH with the wrap bit toggling; count=DEPTH means full.
//  Freeing when already full is illegal (see fl_err).
//  free_count is registered-state derived: equals count in the current cycle.
// CONFIGURATION
//  FREELIST_CHECK_EN defined: fl_err is set and held until reset when any of these occur:
//   - a free would push count above DEPTH;
//   - chead would pass spec_head (chead_next - chead > spec_head - chead);
//   - a grant is given with count<n_req.
//  FREELIST_CHECK_EN undefined: no check logic; fl_err tied to 0.
// TESTING
//  1. Reset then both alloc_req: alloc_ok=1, alloc_prf_0=32, alloc_prf_1=33; next cycle free_count=30.
//  2. Only alloc_req_1 after reset: alloc_prf_1=32, alloc_ok=1; then alloc_req_0 only -> alloc_prf_0=33.
//  3. Drain to count=1, request 2: alloc_ok=0, head unchanged. Free PRF 5 same cycle: next cycle count=2, double alloc succeeds with 32-series leftover then 5.
//  4. Alloc 4 PRFs (32..35), commit_alloc for first 2, recover: next cycle free_count=30, alloc_prf_0=34.
//  5. Recover and free_0_valid (prf 7) in same cycle with alloc_req_0=1: alloc_ok=0, 7 appended at tail, count reflects free.
//  6. With FREELIST_CHECK_EN: free at count=32 -> fl_err=1 next cycle, stays 1 until rst=0. Without the macro, fl_err stays 0.

Source files
------------

// File: rtl/prf_free_list_if.sv
// Rename/commit <-> free-list port bundle. The master is the pipeline side;
// the slave is the free list itself.
interface prf_free_list_if #(
    parameter int PRF_W = 6,
    parameter int CNT_W = 6
);
    logic             recover;
    logic             alloc_req_0;
    logic             alloc_req_1;
    logic             alloc_ok;
    logic [PRF_W-1:0] alloc_prf_0;
    logic [PRF_W-1:0] alloc_prf_1;
    logic             free_0_valid;
    logic [PRF_W-1:0] free_prf_0;
    logic             free_1_valid;
    logic [PRF_W-1:0] free_prf_1;
    logic             commit_alloc_0;
    logic             commit_alloc_1;
    logic [CNT_W-1:0] free_count;
    logic             fl_err;

    modport master (
        output recover, alloc_req_0, alloc_req_1,
        output free_0_valid, free_prf_0, free_1_valid, free_prf_1,
        output commit_alloc_0, commit_alloc_1,
        input  alloc_ok, alloc_prf_0, alloc_prf_1, free_count, fl_err
    );

    modport slave (
        input  recover, alloc_req_0, alloc_req_1,
        input  free_0_valid, free_prf_0, free_1_valid, free_prf_1,
        input  commit_alloc_0, commit_alloc_1,
        output alloc_ok, alloc_prf_0, alloc_prf_1, free_count, fl_err
    );
endinterface

// File: rtl/prf_free_list.sv
// Dual-ported physical-register free list with speculative/committed heads.
// Optional consistency checking is enabled by defining FREELIST_CHECK_EN.
module prf_free_list #(
    parameter int PRF_NUM       = 64,
    parameter int ARF_NUM       = 32,
    parameter int PRF_NUM_WIDTH = $clog2(PRF_NUM),
    parameter int DEPTH         = PRF_NUM - ARF_NUM,
    parameter int PTR_W         = $clog2(DEPTH)
) (
    input logic             clk,
    input logic             rst,
    prf_free_list_if.slave  fl
);

    logic [PTR_W:0]         head_reg, head_next;
    logic [PTR_W:0]         chead_reg, chead_next;
    logic [PTR_W:0]         tail_reg, tail_next;
    logic [PTR_W:0]         head_plus1, tail_plus1;
    logic [PTR_W:0]         count;
    logic [PTR_W:0]         n_req_ext;
    logic [1:0]             n_req, n_free, n_commit;
    logic                   grant;
    logic [PTR_W-1:0]       wr_addr_0, wr_addr_1;
    logic [PRF_NUM_WIDTH-1:0] list_rd [DEPTH];

    assign n_req     = {1'b0, fl.alloc_req_0} + {1'b0, fl.alloc_req_1};
    assign n_free    = {1'b0, fl.free_0_valid} + {1'b0, fl.free_1_valid};
    assign n_commit  = {1'b0, fl.commit_alloc_0} + {1'b0, fl.commit_alloc_1};
    assign n_req_ext = {{(PTR_W-1){1'b0}}, n_req};

    assign count      = tail_reg - head_reg;
    assign head_plus1 = head_reg + {{PTR_W{1'b0}}, 1'b1};
    assign tail_plus1 = tail_reg + {{PTR_W{1'b0}}, 1'b1};

    // All-or-nothing grant; a recover cycle never grants.
    assign grant = !fl.recover && (n_req != 2'd0) && (count >= n_req_ext);

    assign fl.alloc_ok    = grant;
    assign fl.alloc_prf_0 = list_rd[head_reg[PTR_W-1:0]];
    assign fl.alloc_prf_1 = fl.alloc_req_0 ? list_rd[head_plus1[PTR_W-1:0]]
                                           : list_rd[head_reg[PTR_W-1:0]];
    assign fl.free_count  = count;

    // A lone slot-1 free lands at the tail; otherwise it follows slot 0.
    assign wr_addr_0 = tail_reg[PTR_W-1:0];
    assign wr_addr_1 = fl.free_0_valid ? tail_plus1[PTR_W-1:0] : tail_reg[PTR_W-1:0];

    assign tail_next  = tail_reg + {{(PTR_W-1){1'b0}}, n_free};
    assign chead_next = chead_reg + {{(PTR_W-1){1'b0}}, n_commit};

    always_comb begin
        head_next = head_reg;
        if (fl.recover) begin
            head_next = chead_next;
        end else if (grant) begin
            head_next = head_reg + n_req_ext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg  <= '0;
            chead_reg <= '0;
            tail_reg  <= {1'b1, {PTR_W{1'b0}}};
        end else begin
            head_reg  <= head_next;
            chead_reg <= chead_next;
            tail_reg  <= tail_next;
        end
    end

    // Ring storage; entries reset to the PRFs not mapped by the architectural state.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [PRF_NUM_WIDTH-1:0] entry_reg;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                entry_reg <= PRF_NUM_WIDTH'(ARF_NUM + gi);
            end else if (fl.free_1_valid && (wr_addr_1 == PTR_W'(gi))) begin
                entry_reg <= fl.free_prf_1;
            end else if (fl.free_0_valid && (wr_addr_0 == PTR_W'(gi))) begin
                entry_reg <= fl.free_prf_0;
            end
        end

        assign list_rd[gi] = entry_reg;
    end

`ifdef FREELIST_CHECK_EN
    logic             err_reg;
    logic             overflow, chead_pass, under_grant;
    logic [PTR_W+1:0] count_after_free;

    assign count_after_free = {1'b0, count} + {{PTR_W{1'b0}}, n_free};
    assign overflow         = count_after_free > (PTR_W+2)'(DEPTH);
    assign chead_pass       = (chead_next - chead_reg) > (head_reg - chead_reg);
    assign under_grant      = grant && (count < n_req_ext);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_reg <= 1'b0;
        end else if (overflow || chead_pass || under_grant) begin
            err_reg <= 1'b1;
        end
    end

    assign fl.fl_err = err_reg;
`else
    assign fl.fl_err = 1'b0;
`endif

endmodule

// File: tb/tb_prf_free_list.sv
// Randomized + directed scoreboard bench for prf_free_list; the reference model is
// a queue of free PRFs from the committed head plus a count of speculative grants.
module tb_prf_free_list;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prf_free_list_if ifc ();

    prf_free_list dut (
        .clk (clk),
        .rst (rst),
        .fl  (ifc)
    );

    typedef struct {
        logic       ok;
        bit         chk0;
        logic [5:0] p0;
        bit         chk1;
        logic [5:0] p1;
        int         cnt;
        logic       err;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int   avail[$];
    int   spec_taken;
    bit   err_m;
    bit   skip_prf;

    task automatic model_reset();
        avail.delete();
        for (int i = 0; i < 32; i++) avail.push_back(32 + i);
        spec_taken = 0;
        err_m      = 1'b0;
        skip_prf   = 1'b0;
    endtask

    task automatic drive_idle();
        ifc.recover        = 1'b0;
        ifc.alloc_req_0    = 1'b0;
        ifc.alloc_req_1    = 1'b0;
        ifc.free_0_valid   = 1'b0;
        ifc.free_prf_0     = '0;
        ifc.free_1_valid   = 1'b0;
        ifc.free_prf_1     = '0;
        ifc.commit_alloc_0 = 1'b0;
        ifc.commit_alloc_1 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic step(input bit r0, input bit r1, input bit rec,
                        input bit fv0, input logic [5:0] fp0,
                        input bit fv1, input logic [5:0] fp1,
                        input bit ca0, input bit ca1, input string tag);
        exp_t e;
        int cnt, n, nf, c, idx1;
        bit ok;
        ifc.alloc_req_0    = r0;
        ifc.alloc_req_1    = r1;
        ifc.recover        = rec;
        ifc.free_0_valid   = fv0;
        ifc.free_prf_0     = fp0;
        ifc.free_1_valid   = fv1;
        ifc.free_prf_1     = fp1;
        ifc.commit_alloc_0 = ca0;
        ifc.commit_alloc_1 = ca1;

        cnt  = avail.size() - spec_taken;
        n    = int'(r0) + int'(r1);
        nf   = int'(fv0) + int'(fv1);
        c    = int'(ca0) + int'(ca1);
        ok   = !rec && (n != 0) && (cnt >= n);
        idx1 = r0 ? 1 : 0;

        e.ok   = ok;
        e.cnt  = cnt;
        e.err  = err_m;
        e.tag  = tag;
        e.chk0 = !skip_prf && (cnt >= 1);
        e.p0   = e.chk0 ? 6'(avail[spec_taken]) : 6'd0;
        e.chk1 = !skip_prf && (cnt > idx1);
        e.p1   = e.chk1 ? 6'(avail[spec_taken + idx1]) : 6'd0;
        sb.push_back(e);

`ifdef FREELIST_CHECK_EN
        if ((cnt + nf > 32) || (c > spec_taken)) err_m = 1'b1;
`endif
        @(posedge clk);
        if (fv0) avail.push_back(int'(fp0));
        if (fv1) avail.push_back(int'(fp1));
        if (ok) spec_taken += n;
        for (int i = 0; i < c; i++) void'(avail.pop_front());
        spec_taken -= c;
        if (rec) spec_taken = 0;
        #1;
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (rst && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (ifc.alloc_ok !== e.ok) begin
                bad++;
                $display("FAIL %s alloc_ok: got %0b want %0b", e.tag, ifc.alloc_ok, e.ok);
            end
            total++;
            if (ifc.free_count !== 6'(e.cnt)) begin
                bad++;
                $display("FAIL %s free_count: got %0d want %0d", e.tag, ifc.free_count, e.cnt);
            end
            total++;
            if (ifc.fl_err !== e.err) begin
                bad++;
                $display("FAIL %s fl_err: got %0b want %0b", e.tag, ifc.fl_err, e.err);
            end
            if (e.chk0) begin
                total++;
                if (ifc.alloc_prf_0 !== e.p0) begin
                    bad++;
                    $display("FAIL %s alloc_prf_0: got %0d want %0d", e.tag, ifc.alloc_prf_0, e.p0);
                end
            end
            if (e.chk1) begin
                total++;
                if (ifc.alloc_prf_1 !== e.p1) begin
                    bad++;
                    $display("FAIL %s alloc_prf_1: got %0d want %0d", e.tag, ifc.alloc_prf_1, e.p1);
                end
            end
            $display("txn %s ok=%0b cnt=%0d p0=%0d p1=%0d err=%0b", e.tag,
                     ifc.alloc_ok, ifc.free_count, ifc.alloc_prf_0, ifc.alloc_prf_1, ifc.fl_err);
        end
    end

    initial begin
        bit r0, r1, rec, fv0, fv1, ca0, ca1;
        do_reset();

        // 1: reset state, then a double grant
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "t1_reset");
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, "t1_dual");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "t1_after");

        // 2: lone slot-1 request takes the oldest entry
        do_reset();
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, "t2_req1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "t2_req0");

        // 3: drain to one, refused double request with same-cycle free
        do_reset();
        for (int i = 0; i < 15; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, "t3_drain");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, "t3_drain1");
        step(1, 1, 0, 1, 6'd5, 0, 0, 0, 0, "t3_refuse");
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, "t3_dual");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "t3_after");

        // 4: commit two of four grants together with recover
        do_reset();
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, "t4_a");
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, "t4_b");
        step(0, 0, 1, 0, 0, 0, 0, 1, 1, "t4_recover");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "t4_after");

        // 5: recover + free + request in one cycle
        step(1, 0, 1, 1, 6'd7, 0, 0, 0, 0, "t5_recover");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "t5_after");

        // Randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            r0  = 1'($urandom_range(0, 1));
            r1  = 1'($urandom_range(0, 1));
            rec = ($urandom_range(0, 15) == 0);
            ca0 = 1'($urandom_range(0, 1));
            ca1 = 1'($urandom_range(0, 1));
            if (int'(ca0) + int'(ca1) > spec_taken) begin
                ca0 = 1'b0;
                ca1 = 1'b0;
            end
            fv0 = 1'($urandom_range(0, 1));
            fv1 = 1'($urandom_range(0, 1));
            if (avail.size() + int'(fv0) + int'(fv1) > 32) begin
                fv0 = 1'b0;
                fv1 = 1'b0;
            end
            step(r0, r1, rec, fv0, 6'($urandom_range(0, 63)),
                 fv1, 6'($urandom_range(0, 63)), ca0, ca1, "rnd");
        end

        // 6: free into a full list, error stays set until reset
        do_reset();
        step(0, 0, 0, 1, 6'd9, 0, 0, 0, 0, "t6_overfree");
        skip_prf = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, "t6_hold");
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "t6_cleared");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, "t6_idle");

        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
